regwrite_arbiter: RTL and testbench

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter.sv | 137 +++++++++++++
 tb/tb_regwrite_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_arbiter.sv
// Register-bank write arbiter: requester A vs. a one-entry buffered requester B with a
// starvation bound, B-pending scoreboard for decode stalls; optional bypass via REGWR_BYPASS_EN.
module regwrite_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wa_valid,
    input  logic [4:0]  wa_reg,
    input  logic [31:0] wa_data,
    output logic        wa_ack,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_reg,
    input  logic [4:0]  RegLe1,
    input  logic [4:0]  RegLe2,
    output logic        stall,
    output logic [4:0]  RegEscr,
    output logic        EscrReg,
    output logic [31:0] datain,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data
);

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t  state, state_next;
    logic [3:0]  starve_cnt;
    logic [4:0]  buf_reg;
    logic [31:0] buf_data;
    logic        grant_a, grant_b, load_b;
    logic        from_b;
    logic [31:0] pending, pending_next;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (wb_valid) state_next = FULL;
            FULL:  if (grant_b)  state_next = EMPTY;
        endcase
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        load_b  = 1'b0;
        if (!reset) begin
            unique case (state)
                EMPTY: begin
                    grant_a = wa_valid;
                    load_b  = wb_valid;
                end
                FULL: begin
                    if (!wa_valid || starve_cnt == STARVE_LIM) grant_b = 1'b1;
                    else                                       grant_a = 1'b1;
                end
            endcase
        end
    end

    assign wa_ack   = grant_a;
    assign wb_ready = (state == EMPTY);

    // NOTE: payload flops carry no reset; they are only observed while state is FULL.
    always_ff @(posedge clk) begin
        if (load_b) begin
            buf_reg  <= wb_reg;
            buf_data <= wb_data;
        end
    end

    // NOTE: default first so every path assigns pending_next and no latch is inferred.
    always_comb begin
        pending_next = pending;
        if (EscrReg && from_b)               pending_next[RegEscr] = 1'b0;
        if (iss_valid && iss_reg != 5'd0)    pending_next[iss_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            pending    <= '0;
            EscrReg    <= 1'b0;
            RegEscr    <= '0;
            datain     <= '0;
            from_b     <= 1'b0;
        end else begin
            pending <= pending_next;
            if (grant_b)                      starve_cnt <= '0;
            else if (grant_a && state == FULL) starve_cnt <= starve_cnt + 4'd1;

            if (grant_a) begin
                RegEscr <= wa_reg;
                datain  <= wa_data;
                EscrReg <= |wa_reg;
                from_b  <= 1'b0;
            end else if (grant_b) begin
                RegEscr <= buf_reg;
                datain  <= buf_data;
                EscrReg <= |buf_reg;
                from_b  <= 1'b1;
            end else begin
                EscrReg <= 1'b0;
                from_b  <= 1'b0;
            end
        end
    end

`ifdef REGWR_BYPASS_EN
    always_comb begin
        fwd_hit1 = !reset && state == FULL && buf_reg != 5'd0 && buf_reg == RegLe1;
        fwd_hit2 = !reset && state == FULL && buf_reg != 5'd0 && buf_reg == RegLe2;
        fwd_data = (!reset && state == FULL) ? buf_data : '0;
    end
`else
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        fwd_data = '0;
    end
`endif

    // A forwarded read port never waits on the bank write.
    assign stall = !reset && ((pending[RegLe1] && !fwd_hit1) || (pending[RegLe2] && !fwd_hit2));

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regwrite_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef REGWR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wa_valid = 0, wb_valid = 0, iss_valid = 0;
    logic [4:0]  wa_reg = 0, wb_reg = 0, iss_reg = 0, RegLe1 = 0, RegLe2 = 0;
    logic [31:0] wa_data = 0, wb_data = 0;
    logic        wa_ack, wb_ready, stall, EscrReg, fwd_hit1, fwd_hit2;
    logic [4:0]  RegEscr;
    logic [31:0] datain, fwd_data;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 0;

    regwrite_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .wa_valid(wa_valid), .wa_reg(wa_reg), .wa_data(wa_data), .wa_ack(wa_ack),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
        .iss_valid(iss_valid), .iss_reg(iss_reg),
        .RegLe1(RegLe1), .RegLe2(RegLe2), .stall(stall),
        .RegEscr(RegEscr), .EscrReg(EscrReg), .datain(datain),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_full;
    logic [4:0]  m_breg;
    logic [31:0] m_bdata;
    int          m_a_wins;         // consecutive A grants while B waits in the buffer
    bit          m_pend [32];
    bit          m_we, m_we_b, m_last_a_ack;
    logic [4:0]  m_wreg = 0;
    logic [31:0] m_wdata = 0;

    function automatic bit m_grant_a();
        return !reset && wa_valid && (!m_full || m_a_wins < STARVE_MAX);
    endfunction

    function automatic bit m_grant_b();
        return !reset && m_full && (!wa_valid || m_a_wins >= STARVE_MAX);
    endfunction

    function automatic bit m_hit(input logic [4:0] a);
        return BYP && !reset && m_full && m_breg == a && m_breg != 5'd0;
    endfunction

    function automatic bit m_stall();
        return !reset && ((m_pend[RegLe1] && !m_hit(RegLe1)) || (m_pend[RegLe2] && !m_hit(RegLe2)));
    endfunction

    always @(posedge clk) begin : model
        bit ga, gb;
        ga = m_grant_a();
        gb = m_grant_b();
        if (reset) begin
            m_full = 0; m_a_wins = 0; m_we = 0; m_we_b = 0; m_last_a_ack = 0;
            m_wreg = 0; m_wdata = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else begin
            if (m_we && m_we_b) m_pend[m_wreg] = 0;
            if (iss_valid && iss_reg != 0) m_pend[iss_reg] = 1;
            m_last_a_ack = ga;
            if (ga) begin
                m_we = (wa_reg != 0); m_we_b = 0; m_wreg = wa_reg; m_wdata = wa_data;
            end else if (gb) begin
                m_we = (m_breg != 0); m_we_b = 1; m_wreg = m_breg; m_wdata = m_bdata;
            end else begin
                m_we = 0; m_we_b = 0;
            end
            if (gb) begin
                m_full = 0; m_a_wins = 0;
            end else if (m_full && ga) begin
                m_a_wins++;
            end else if (!m_full && wb_valid) begin
                m_full = 1; m_breg = wb_reg; m_bdata = wb_data;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wa_ack", wa_ack, m_grant_a());
            check("stall", stall, m_stall());
            check("fwd_hit1", fwd_hit1, m_hit(RegLe1));
            check("fwd_hit2", fwd_hit2, m_hit(RegLe2));
            if (m_hit(RegLe1) || m_hit(RegLe2)) check("fwd_data", fwd_data, m_bdata);
            else if (!BYP)                      check("fwd_data_off", fwd_data, 0);
            if (!reset) begin
                check("wb_ready", wb_ready, !m_full);
                check("EscrReg", EscrReg, m_we);
                check("RegEscr", RegEscr, m_wreg);
                check("datain", datain, m_wdata);
            end
        end
    end

    bit watch9 = 0, saw9 = 0;
    always @(negedge clk) if (watch9 && EscrReg && RegEscr == 5'd9) saw9 = 1;

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wa_valid = 0; wb_valid = 0; iss_valid = 0;
        wa_reg = 0; wb_reg = 0; iss_reg = 0; wa_data = 0; wb_data = 0;
        RegLe1 = 0; RegLe2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        int acks;
        idle_inputs();
        tick();
        cmp_en = 1;
        do_reset();

        // reset state, then a single A write
        @(negedge clk);
        check("rst_wb_ready", wb_ready, 1);
        check("rst_EscrReg", EscrReg, 0);
        check("rst_RegEscr", RegEscr, 0);
        check("rst_datain", datain, 0);
        check("rst_stall", stall, 0);
        check("rst_fwd_data", fwd_data, 0);
        tick();
        wa_valid = 1; wa_reg = 3; wa_data = 32'h11;
        @(negedge clk);
        check("a_ack", wa_ack, 1);
        tick();
        wa_valid = 0;
        @(negedge clk);
        check("a_EscrReg", EscrReg, 1);
        check("a_RegEscr", RegEscr, 3);
        check("a_datain", datain, 32'h11);
        tick();

        // scoreboard stall across a B write of reg 5
        do_reset();
        iss_valid = 1; iss_reg = 5; RegLe1 = 5;
        @(negedge clk);
        check("sb_stall_c0", stall, 0);
        tick();
        iss_valid = 0; wb_valid = 1; wb_reg = 5; wb_data = 32'hAB;
        @(negedge clk);
        check("sb_stall_c1", stall, 1);
        tick();
        wb_valid = 0;
        @(negedge clk);
        check("sb_stall_c2", stall, !BYP);
        check("sb_fwd1_c2", fwd_hit1, BYP);
        tick();
        @(negedge clk);
        check("sb_EscrReg", EscrReg, 1);
        check("sb_RegEscr", RegEscr, 5);
        check("sb_datain", datain, 32'hAB);
        check("sb_stall_c3", stall, 1);
        tick();
        @(negedge clk);
        check("sb_stall_c4", stall, 0);
        tick();

        // starvation bound: 4 A grants, then B, then A again
        do_reset();
        wb_valid = 1; wb_reg = 6; wb_data = 32'h66;
        tick();
        wb_valid = 0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            wa_valid = 1; wa_reg = 1; wa_data = acks;
            @(negedge clk);
            check($sformatf("starve_ack%0d", i), wa_ack, (i != 4));
            if (i == 4) check("starve_ready4", wb_ready, 0);
            if (i == 5) begin
                check("starve_ready5", wb_ready, 1);
                check("starve_b_reg", RegEscr, 6);
                check("starve_b_data", datain, 32'h66);
            end
            if (wa_ack) acks++;
            tick();
        end
        wa_valid = 0;
        tick();

        // register 0 writes from both sides are consumed silently
        do_reset();
        iss_valid = 1; iss_reg = 4; RegLe1 = 4;
        wb_valid = 1; wb_reg = 0; wb_data = 32'hDEAD;
        wa_valid = 1; wa_reg = 0; wa_data = 32'hBEEF;
        @(negedge clk);
        check("r0_a_ack", wa_ack, 1);
        tick();
        iss_valid = 0; wb_valid = 0; wa_valid = 0;
        @(negedge clk);
        check("r0_EscrReg_a", EscrReg, 0);
        tick();
        @(negedge clk);
        check("r0_EscrReg_b", EscrReg, 0);
        check("r0_ready", wb_ready, 1);
        tick();
        @(negedge clk);
        check("r0_EscrReg_c", EscrReg, 0);
        check("r0_stall", stall, 1);
        tick();

        // bypass of a buffered reg 7 while A keeps winning
        do_reset();
        iss_valid = 1; iss_reg = 7; wb_valid = 1; wb_reg = 7; wb_data = 32'h55;
        tick();
        iss_valid = 0; wb_valid = 0; wa_valid = 1; wa_reg = 2; wa_data = 32'h22; RegLe2 = 7;
        @(negedge clk);
        check("byp_ack", wa_ack, 1);
        check("byp_hit2", fwd_hit2, BYP);
        check("byp_data", fwd_data, BYP ? 32'h55 : 32'h0);
        check("byp_stall", stall, !BYP);
        tick();
        wa_valid = 0;
        repeat (3) tick();

        // reset while FULL drops the buffered write and pending bits
        do_reset();
        iss_valid = 1; iss_reg = 9; wb_valid = 1; wb_reg = 9; wb_data = 32'h99;
        tick();
        iss_valid = 0; wb_valid = 0; wa_valid = 1; wa_reg = 1; wa_data = 32'h1;
        RegLe1 = 9; reset = 1; watch9 = 1;
        @(negedge clk);
        check("rf_ack_in_reset", wa_ack, 0);
        check("rf_stall_in_reset", stall, 0);
        tick();
        reset = 0; wa_valid = 0;
        @(negedge clk);
        check("rf_ready", wb_ready, 1);
        check("rf_stall", stall, 0);
        repeat (8) tick();
        check("rf_no_reg9_write", saw9, 0);
        watch9 = 0;

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!(wa_valid && !m_last_a_ack)) begin
                wa_valid = ($urandom_range(0, 2) != 0);
                wa_reg   = 5'($urandom_range(0, 7));
                wa_data  = $urandom;
            end
            wb_valid  = $urandom_range(0, 1);
            wb_reg    = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_reg   = 5'($urandom_range(0, 7));
            RegLe1    = 5'($urandom_range(0, 7));
            RegLe2    = 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        reset = 0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
